div_32_seq: RTL and testbench
=============================

# div_32_seq

Multi-cycle signed 32-bit divider that accepts a division request from the datapath control sequence and returns the quotient and remainder for the LO and HI registers. The sequencer asserts `start` in the cycle it drives the divisor on the bus, with the dividend already held in Y. It then waits for `done` before pulsing HIin/LOin. The divider replaces the single-cycle combinational divide with an iterative restoring divider: one quotient bit per clock.

## Interface
- `WIDTH`, default 32: operand width. Only 32 is verified.
- `Clock` in 1: rising-edge clock.
- `Clear` in 1: asynchronous, active-low reset.
- `start` in 1: request strobe, sampled on the rising edge.
- `dividend` in WIDTH: signed dividend (Y register value).
- `divisor` in WIDTH: signed divisor (bus value).
- `busy` out 1: a division is in progress.
- `done` out 1: one-cycle pulse; `quotient` and `remainder` are valid.
- `quotient` out WIDTH: signed quotient, destined for LO.
- `remainder` out WIDTH: signed remainder, destined for HI.
- `div_zero` out 1: the last result came from a zero divisor.

## Operation
- The FSM has five states: IDLE, PREP, ITER, FIX, DONE.
- IDLE
  - `start`=1 captures `dividend` and `divisor` into internal registers and moves to PREP.
  - `start`=0 stays in IDLE.
- PREP
  - Stores the absolute values of both operands, the result sign (sign(dividend) XOR sign(divisor)) and the remainder sign (sign(dividend)).
  - Clears the partial remainder, loads the iteration counter with 31, and moves to ITER.
- ITER, restoring step
  - Shift {partial remainder, quotient} left by one.
  - Trial-subtract |divisor| from the partial remainder using a 33-bit subtract.
  - A non-negative result commits the subtraction and sets quotient bit 0 to 1. A negative result keeps the partial remainder and sets bit 0 to 0.
  - The counter decrements each cycle. ITER moves to FIX after the step taken with the counter at 0, which gives exactly 32 steps.
- FIX
  - Negates the quotient if the result sign is set, and negates the remainder if the dividend was negative.
  - Writes both to the `quotient`/`remainder` output registers and moves to DONE.
- DONE asserts `done` for one cycle and returns to IDLE.
- Semantics: the quotient truncates toward zero and the remainder takes the sign of the dividend, so dividend = quotient*divisor + remainder.
- Divisor of zero
  - The ITER steps still run, so latency is unchanged.
  - FIX forces `quotient`=32'hFFFFFFFF and `remainder`=dividend, and sets `div_zero`=1.
- Overflow: 32'h80000000 / 32'hFFFFFFFF yields `quotient`=32'h80000000, `remainder`=0, `div_zero`=0. The unsigned magnitude path produces this naturally and no special case is allowed to alter it.
- `start` while `busy` is ignored and does not disturb the operation in flight.
- `quotient`, `remainder` and `div_zero` hold their values from FIX until the next FIX.
- `div_zero` is updated only in FIX.

## Timing
- Reset (`Clear`=0, asynchronous, at any time including mid-ITER):
  - State returns to IDLE.
  - `busy`=0, `done`=0, `quotient`=0, `remainder`=0, `div_zero`=0, and all internal registers are cleared.
  - An aborted operation produces no `done`.
- Count cycles from edge E, the edge at which `start`=1 is sampled in IDLE:
  - PREP occupies E+1.
  - The ITER steps occupy edges E+2 through E+33.
  - FIX occupies E+34.
  - `done` is high during the cycle after edge E+34.
  - Latency is 35 clocks from the start edge to the `done` edge, and it is data-independent.
- `busy` goes high after edge E and drops with `done` after DONE; `busy` is 1 throughout DONE.
- A new `start` is accepted on the first edge at which the FSM is back in IDLE, i.e. the edge that ends the DONE cycle is not an accepting edge. Back-to-back operations are therefore 36 clocks apart.
- `done` and `busy` are registered outputs with no combinational path from `start`.
- The sequencer must assert HIin/LOin only in the cycle `done`=1 or later.

## Test plan
- Basic: dividend=32'h00000014, divisor=32'h00000012, start for 1 cycle. Required: `done` 35 clocks later, `quotient`=1, `remainder`=2, `div_zero`=0, a single-cycle `done`.
- Signs:
  - -7 / 2 gives Q=-3 (32'hFFFFFFFD), R=-1.
  - 7 / -2 gives Q=-3, R=1.
  - -7 / -2 gives Q=3, R=-1.
  - Random signed pairs must match a reference model with truncation toward zero.
- Divide by zero: 32'h00001234 / 0 gives Q=32'hFFFFFFFF, R=32'h00001234, `div_zero`=1. A following 10/3 clears `div_zero` and gives Q=3, R=1.
- Overflow and extremes:
  - 32'h80000000 / -1 gives Q=32'h80000000, R=0.
  - 32'h80000000 / 1 gives Q=32'h80000000, R=0.
  - 0 / 5 gives Q=0, R=0.
  - 32'h7FFFFFFF / 32'h7FFFFFFF gives Q=1, R=0.
- Handshake:
  - Holding `start`=1 continuously yields one operation per 36 clocks.
  - A `start` pulse with new operands mid-ITER is ignored; the result matches the original operands.
- Reset mid-operation: drop `Clear` at clock 10 of a divide. Required: outputs zero immediately with no clock needed, no `done` is produced, and a fresh divide after release gives correct results at full 35-clock latency.

Source files
------------

// File: rtl/div_32_seq_if.sv
// Request/response bundle between the datapath sequencer and the sequential divider.
// The sequencer is the master; the divider is the slave.
interface div_32_seq_if #(
   parameter int WIDTH = 32
);

   logic             start;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             div_zero;

   modport master (
      output start, dividend, divisor,
      input  busy, done, quotient, remainder, div_zero
   );

   modport slave (
      input  start, dividend, divisor,
      output busy, done, quotient, remainder, div_zero
   );

endinterface

// File: rtl/div_32_seq.sv
// Iterative signed restoring divider: one quotient bit per clock on operand magnitudes,
// with signs restored at the end. Quotient truncates toward zero; remainder follows the dividend.
module div_32_seq #(
   parameter int WIDTH = 32
) (
   input logic          Clock,
   input logic          Clear,
   div_32_seq_if.slave  bus
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_t;

   state_t           r_state;
   state_t           w_nextState;

   logic [WIDTH-1:0] r_dividend;
   logic [WIDTH-1:0] r_divisor;
   logic [WIDTH-1:0] r_absDivisor;
   logic [WIDTH-1:0] r_rem;
   logic [WIDTH-1:0] r_quo;
   logic             r_quoSign;
   logic             r_remSign;
   logic [CW-1:0]    r_count;
   logic [WIDTH-1:0] r_quotient;
   logic [WIDTH-1:0] r_remainder;
   logic             r_divZero;
   logic             r_busy;
   logic             r_done;

   logic [WIDTH-1:0] w_absDividend;
   logic [WIDTH-1:0] w_absDivisor;
   logic [WIDTH-1:0] w_shift;
   logic [WIDTH:0]   w_trial;

   // The most negative value maps onto itself, which reads correctly as an unsigned magnitude.
   assign w_absDividend = r_dividend[WIDTH-1] ? -r_dividend : r_dividend;
   assign w_absDivisor  = r_divisor[WIDTH-1]  ? -r_divisor  : r_divisor;

   // The partial remainder stays below |divisor| <= 2^(WIDTH-1), so the shift never loses a bit.
   assign w_shift = {r_rem[WIDTH-2:0], r_quo[WIDTH-1]};
   assign w_trial = {1'b0, w_shift} - {1'b0, r_absDivisor};

   always_ff @(posedge Clock or negedge Clear) begin
      if (!Clear) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE:    if (bus.start) w_nextState = PREP;
         PREP:    w_nextState = ITER;
         ITER:    if (r_count == '0) w_nextState = FIX;
         FIX:     w_nextState = DONE;
         DONE:    w_nextState = IDLE;
         default: w_nextState = IDLE;
      endcase
   end

   always_ff @(posedge Clock or negedge Clear) begin
      if (!Clear) begin
         r_dividend   <= '0;
         r_divisor    <= '0;
         r_absDivisor <= '0;
         r_rem        <= '0;
         r_quo        <= '0;
         r_quoSign    <= 1'b0;
         r_remSign    <= 1'b0;
         r_count      <= '0;
         r_quotient   <= '0;
         r_remainder  <= '0;
         r_divZero    <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
      end else begin
         r_busy <= (w_nextState != IDLE);
         r_done <= (w_nextState == DONE);
         case (r_state)
            IDLE: begin
               if (bus.start) begin
                  r_dividend <= bus.dividend;
                  r_divisor  <= bus.divisor;
               end
            end
            PREP: begin
               r_quo        <= w_absDividend;
               r_absDivisor <= w_absDivisor;
               r_quoSign    <= r_dividend[WIDTH-1] ^ r_divisor[WIDTH-1];
               r_remSign    <= r_dividend[WIDTH-1];
               r_rem        <= '0;
               r_count      <= CW'(WIDTH - 1);
            end
            ITER: begin
               if (!w_trial[WIDTH]) begin
                  r_rem <= w_trial[WIDTH-1:0];
                  r_quo <= {r_quo[WIDTH-2:0], 1'b1};
               end else begin
                  r_rem <= w_shift;
                  r_quo <= {r_quo[WIDTH-2:0], 1'b0};
               end
               r_count <= r_count - CW'(1);
            end
            FIX: begin
               if (r_divisor == '0) begin
                  r_quotient  <= '1;
                  r_remainder <= r_dividend;
                  r_divZero   <= 1'b1;
               end else begin
                  r_quotient  <= r_quoSign ? -r_quo : r_quo;
                  r_remainder <= r_remSign ? -r_rem : r_rem;
                  r_divZero   <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.busy      = r_busy;
   assign bus.done      = r_done;
   assign bus.quotient  = r_quotient;
   assign bus.remainder = r_remainder;
   assign bus.div_zero  = r_divZero;

endmodule

// File: tb/tb_div_32_seq.sv
// Bench for div_32_seq: a cycle-level reference model checked every cycle, plus directed
// vectors whose hand-computed results also pin the reference model.
module tb_div_32_seq;

   typedef struct packed {
      logic [31:0] q;
      logic [31:0] r;
      logic        z;
   } res_t;

   logic Clock = 1'b0;
   logic Clear = 1'b0;

   int assertCount = 0;
   int failCount   = 0;

   always #5 Clock = ~Clock;

   div_32_seq_if #(.WIDTH(32)) bus ();

   div_32_seq #(.WIDTH(32)) dut (
      .Clock (Clock),
      .Clear (Clear),
      .bus   (bus)
   );

   // Truncating signed division with the two architected corner cases made explicit.
   function automatic res_t refModel(input logic [31:0] a, input logic [31:0] b);
      res_t res;
      int   sa;
      int   sb;
      sa = $signed(a);
      sb = $signed(b);
      if (b == 32'd0) begin
         res.q = 32'hFFFFFFFF;
         res.r = a;
         res.z = 1'b1;
      end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
         res.q = 32'h80000000;
         res.r = 32'd0;
         res.z = 1'b0;
      end else begin
         res.q = sa / sb;
         res.r = sa % sb;
         res.z = 1'b0;
      end
      return res;
   endfunction

   task automatic checkValue(input string name, input logic [31:0] actual, input logic [31:0] required);
      assertCount++;
      if (actual !== required) begin
         failCount++;
         $display("[TB] FAIL %s actual=%h required=%h at %0t", name, actual, required, $time);
      end
   endtask

   // Timing model: an accepted start at edge E yields done in the cycle after edge E+34,
   // results visible from that same cycle, and the next acceptance at edge E+36 or later.
   int   cyc    = 0;
   int   opEdge = -1000;
   res_t pend   = '0;
   res_t held   = '0;

   always @(posedge Clock) begin
      cyc <= cyc + 1;
      if (!Clear) begin
         opEdge <= -1000;
         held   <= '0;
      end else begin
         if (cyc + 1 == opEdge + 34) held <= pend;
         if (bus.start && (cyc + 1 - opEdge >= 36)) begin
            opEdge <= cyc + 1;
            pend   <= refModel(bus.dividend, bus.divisor);
         end
      end
   end

   always @(negedge Clock) begin
      int d;
      d = cyc - opEdge;
      checkValue("model busy", 32'(bus.busy), 32'(d >= 0 && d <= 34));
      checkValue("model done", 32'(bus.done), 32'(d == 34));
      checkValue("model quotient", bus.quotient, held.q);
      checkValue("model remainder", bus.remainder, held.r);
      checkValue("model div_zero", 32'(bus.div_zero), 32'(held.z));
   end

   task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b);
      @(negedge Clock);
      bus.dividend = a;
      bus.divisor  = b;
      bus.start    = 1'b1;
      @(negedge Clock);
      bus.start    = 1'b0;
   endtask

   task automatic waitDone(input int startEdges, output int edges);
      edges = startEdges;
      while (!bus.done && edges < 60) begin
         @(negedge Clock);
         edges++;
      end
      if (!bus.done) begin
         failCount++;
         assertCount++;
         $display("[TB] FAIL done timeout actual=0 required=1 after %0d edges", edges);
      end
   endtask

   task automatic checkOutput(input string name, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] expQ, input logic [31:0] expR, input logic expZ);
      res_t m;
      int   edges;
      m = refModel(a, b);
      checkValue({name, " refQ"}, m.q, expQ);
      checkValue({name, " refR"}, m.r, expR);
      applyStimulus(a, b);
      waitDone(1, edges);
      checkValue({name, " latency"}, edges, 35);
      checkValue({name, " Q"}, bus.quotient, expQ);
      checkValue({name, " R"}, bus.remainder, expR);
      checkValue({name, " Z"}, 32'(bus.div_zero), 32'(expZ));
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL global timeout actual=running required=finished");
      $fatal(1, "[TB] simulation did not finish");
   end

   initial begin
      int   edges;
      int   doneSeen;
      res_t m;
      logic [31:0] a;
      logic [31:0] b;

      bus.start    = 1'b0;
      bus.dividend = '0;
      bus.divisor  = '0;
      repeat (3) @(negedge Clock);
      checkValue("reset busy", 32'(bus.busy), 32'd0);
      checkValue("reset done", 32'(bus.done), 32'd0);
      checkValue("reset Q", bus.quotient, 32'd0);
      checkValue("reset R", bus.remainder, 32'd0);
      checkValue("reset Z", 32'(bus.div_zero), 32'd0);
      Clear = 1'b1;

      checkOutput("basic", 32'h00000014, 32'h00000012, 32'h00000001, 32'h00000002, 1'b0);
      checkOutput("neg/pos", 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0);
      checkOutput("pos/neg", 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000001, 1'b0);
      checkOutput("neg/neg", 32'hFFFFFFF9, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 1'b0);
      checkOutput("100/-7", 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2, 32'h00000002, 1'b0);
      checkOutput("divzero", 32'h00001234, 32'h00000000, 32'hFFFFFFFF, 32'h00001234, 1'b1);
      checkOutput("after zero", 32'd10, 32'd3, 32'd3, 32'd1, 1'b0);
      checkOutput("neg divzero", 32'hFFFFFF9C, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFF9C, 1'b1);
      checkOutput("overflow", 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 1'b0);
      checkOutput("min/1", 32'h80000000, 32'h00000001, 32'h80000000, 32'h00000000, 1'b0);
      checkOutput("min/min", 32'h80000000, 32'h80000000, 32'h00000001, 32'h00000000, 1'b0);
      checkOutput("zero/5", 32'h00000000, 32'h00000005, 32'h00000000, 32'h00000000, 1'b0);
      checkOutput("max/max", 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h00000001, 32'h00000000, 1'b0);

      for (int i = 0; i < 8; i++) begin
         a = $urandom;
         b = (i < 4) ? $urandom : 32'($urandom_range(1, 100));
         if (i % 2 == 1) b = -b;
         m = refModel(a, b);
         applyStimulus(a, b);
         waitDone(1, edges);
         checkValue("random latency", edges, 35);
         checkValue("random Q", bus.quotient, m.q);
         checkValue("random R", bus.remainder, m.r);
      end

      // Held start: one operation every 36 clocks.
      @(negedge Clock);
      bus.dividend = 32'd1000;
      bus.divisor  = 32'd7;
      bus.start    = 1'b1;
      @(negedge Clock);
      waitDone(1, edges);
      checkValue("held start first latency", edges, 35);
      for (int k = 0; k < 2; k++) begin
         @(negedge Clock);
         waitDone(1, edges);
         checkValue("held start spacing", edges, 36);
         checkValue("held start Q", bus.quotient, 32'd142);
         checkValue("held start R", bus.remainder, 32'd6);
      end
      bus.start = 1'b0;

      // A start strobe mid-ITER must not disturb the operation in flight.
      applyStimulus(32'd500, 32'hFFFFFFF7);
      repeat (10) @(negedge Clock);
      bus.dividend = 32'd9999;
      bus.divisor  = 32'd3;
      bus.start    = 1'b1;
      @(negedge Clock);
      bus.start    = 1'b0;
      waitDone(12, edges);
      checkValue("ignore start latency", edges, 35);
      checkValue("ignore start Q", bus.quotient, 32'hFFFFFFC9);
      checkValue("ignore start R", bus.remainder, 32'h00000005);

      // Asynchronous reset at clock 10 of a divide.
      applyStimulus(32'd12345, 32'd6);
      repeat (9) @(negedge Clock);
      #2 Clear = 1'b0;
      #1;
      checkValue("async reset busy", 32'(bus.busy), 32'd0);
      checkValue("async reset done", 32'(bus.done), 32'd0);
      checkValue("async reset Q", bus.quotient, 32'd0);
      checkValue("async reset R", bus.remainder, 32'd0);
      checkValue("async reset Z", 32'(bus.div_zero), 32'd0);
      repeat (3) @(negedge Clock);
      Clear = 1'b1;
      doneSeen = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge Clock);
         if (bus.done) doneSeen++;
      end
      checkValue("aborted op done count", doneSeen, 0);
      checkOutput("after reset", 32'd12345, 32'd6, 32'h00000809, 32'h00000003, 1'b0);

      repeat (3) @(negedge Clock);
      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
